// File: rtl/xdsp_pkg.sv
// ---------------------------------------------------------------------------
// xdsp_pkg
// Helpers shared by the signed DSP blocks:
//   clog2        - ceiling log2 usable in constant expressions
//   cnt_width    - width of a 0..len-1 counter (never less than 1 bit)
//   acc_width_ok - checks that an accumulator of bwid_acc bits holding the
//                  sum of len signed bwid_in-bit values cannot wrap
//   sat_max      - largest value of a signed number of the given width
//   sat_min      - smallest value of a signed number of the given width
//   round_const  - half-LSB addend for round-half-up before a right shift
// ---------------------------------------------------------------------------
package xdsp_pkg;

  function automatic int clog2(input int value);
    int result;
    int rest;
    result = 0;
    rest   = value - 1;
    while (rest > 0) begin
      result = result + 1;
      rest   = rest >> 1;
    end
    return result;
  endfunction

  function automatic int cnt_width(input int len);
    return (len > 1) ? clog2(len) : 1;
  endfunction

  function automatic bit acc_width_ok(input int bwid_in, input int bwid_acc,
                                      input int len);
    return (len >= 1) && (bwid_acc >= bwid_in + clog2(len));
  endfunction

  function automatic longint sat_max(input int width);
    return (longint'(1) << (width - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int width);
    return -(longint'(1) << (width - 1));
  endfunction

  // A zero shift means the value passes through untouched, so no addend.
  function automatic longint round_const(input int shift);
    return (shift == 0) ? longint'(0) : (longint'(1) << (shift - 1));
  endfunction

endpackage

// File: rtl/xround_sat.sv
// ---------------------------------------------------------------------------
// xround_sat
// Two-stage round / shift / saturate pipeline placed behind an accumulator.
//   R stage: rnd = (iData + 2^(SHIFT-1)) >>> SHIFT, one bit wider than iData
//            so the rounding addend can never overflow.
//   S stage: clip rnd to the signed BWID_OUT range, flag clipping on oSat.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   iValid, iData   value to round (signed, BWID_IN bits) and its qualifier
//   oValid          one-cycle strobe, two clocks after iValid
//   oData, oSat     rounded/saturated result and clip flag, held between
//                   strobes
// ---------------------------------------------------------------------------
module xround_sat
  import xdsp_pkg::*;
#(
  parameter int BWID_IN  = 48,
  parameter int BWID_OUT = 16,
  parameter int SHIFT    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       iValid,
  input  logic signed [BWID_IN-1:0]  iData,
  output logic                       oValid,
  output logic signed [BWID_OUT-1:0] oData,
  output logic                       oSat
);

  localparam int W = BWID_IN + 1;

  localparam logic signed [W-1:0] RND_ADD = W'(round_const(SHIFT));
  localparam logic signed [W-1:0] OUT_MAX = W'(sat_max(BWID_OUT));
  localparam logic signed [W-1:0] OUT_MIN = W'(sat_min(BWID_OUT));

  generate
    if (BWID_OUT > W || SHIFT < 0 || SHIFT >= W) begin : g_bad_params
      $error("xround_sat: BWID_OUT or SHIFT out of range for BWID_IN");
    end
  endgenerate

  logic signed [W-1:0] ext;
  logic signed [W-1:0] biased;
  logic signed [W-1:0] rnd;
  logic                rnd_valid;
  logic                clip_hi;
  logic                clip_lo;

  assign ext     = {iData[BWID_IN-1], iData};
  assign biased  = ext + RND_ADD;
  assign clip_hi = (rnd > OUT_MAX);
  assign clip_lo = (rnd < OUT_MIN);

  // R stage: rnd only loads with a valid input so it keeps the last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnd_valid <= 1'b0;
      rnd       <= '0;
    end else begin
      rnd_valid <= iValid;
      if (iValid) begin
        rnd <= biased >>> SHIFT;
      end
    end
  end

  // S stage: the strobe follows rnd_valid every cycle, data/flag only load
  // with it so they hold until the next result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oValid <= 1'b0;
      oData  <= '0;
      oSat   <= 1'b0;
    end else begin
      oValid <= rnd_valid;
      if (rnd_valid) begin
        if (clip_hi) begin
          oData <= OUT_MAX[BWID_OUT-1:0];
          oSat  <= 1'b1;
        end else if (clip_lo) begin
          oData <= OUT_MIN[BWID_OUT-1:0];
          oSat  <= 1'b1;
        end else begin
          oData <= rnd[BWID_OUT-1:0];
          oSat  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/xaccum_signed.sv
// ---------------------------------------------------------------------------
// xaccum_signed
// Signed block accumulator behind the pipelined multiplier. Sums LEN
// qualified products, then rounds (half-up), right-shifts by SHIFT and
// saturates to BWID_OUT bits. One result per block, no backpressure, and a
// new block may start the cycle after the last sample of the previous one.
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   iValid     iData qualifier
//   iData      signed product, BWID_IN bits
//   iClr       synchronous block restart, discards the partial sum; a sample
//              arriving with it becomes sample 0 of the new block
//   oValid     one-cycle strobe, three clocks after the final sample
//   oData      signed result, held until the next strobe
//   oSat       result was clipped, held with oData
//   oBusy      a partial block is in progress (sample count != 0)
// ---------------------------------------------------------------------------
module xaccum_signed
  import xdsp_pkg::*;
#(
  parameter int BWID_IN  = 33,
  parameter int BWID_ACC = 48,
  parameter int BWID_OUT = 16,
  parameter int SHIFT    = 16,
  parameter int LEN      = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       iValid,
  input  logic signed [BWID_IN-1:0]  iData,
  input  logic                       iClr,
  output logic                       oValid,
  output logic signed [BWID_OUT-1:0] oData,
  output logic                       oSat,
  output logic                       oBusy
);

  localparam int            CW   = cnt_width(LEN);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  generate
    if (!acc_width_ok(BWID_IN, BWID_ACC, LEN)) begin : g_bad_acc
      $error("xaccum_signed: BWID_ACC too narrow for BWID_IN and LEN");
    end
  endgenerate

  logic [CW-1:0]              cnt;
  logic [CW-1:0]              cnt_base;
  logic [CW-1:0]              cnt_next;
  logic signed [BWID_ACC-1:0] acc;
  logic signed [BWID_ACC-1:0] sample;
  logic                       block_start;
  logic                       last_sample;
  logic                       dump;

  assign sample = BWID_ACC'(iData);

  // iClr makes the current sample position 0 regardless of cnt, so a sample
  // arriving with it is handled exactly like the first sample of a block.
  always_comb begin
    block_start = iClr | (cnt == '0);
    cnt_base    = iClr ? '0 : cnt;
    last_sample = iValid & (cnt_base == LAST);
    cnt_next    = cnt_base;
    if (iValid) begin
      cnt_next = last_sample ? '0 : cnt_base + CW'(1);
    end
  end

  // The first sample overwrites acc instead of adding, so no separate clear
  // cycle is needed between back-to-back blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      acc   <= '0;
      dump  <= 1'b0;
      oBusy <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      dump  <= last_sample;
      oBusy <= (cnt_next != '0);
      if (iValid) begin
        acc <= block_start ? sample : acc + sample;
      end
    end
  end

  // dump and acc are aligned: the R stage reads the finished sum on the same
  // edge that a following block may overwrite acc with its first sample.
  xround_sat #(
    .BWID_IN (BWID_ACC),
    .BWID_OUT(BWID_OUT),
    .SHIFT   (SHIFT)
  ) u_round_sat (
    .clk   (clk),
    .rst   (rst),
    .iValid(dump),
    .iData (acc),
    .oValid(oValid),
    .oData (oData),
    .oSat  (oSat)
  );

endmodule

// File: tb/tb_xaccum_signed.sv
// ---------------------------------------------------------------------------
// tb_xaccum_signed
// Self-checking bench for xaccum_signed (BWID_IN=33, BWID_ACC=48,
// BWID_OUT=16, SHIFT=8, LEN=4). A block-level reference model counts
// samples, sums them with plain integer arithmetic, and computes the
// rounded/clipped result; expected results are queued with the cycle in
// which the strobe must appear.
// ---------------------------------------------------------------------------
module tb_xaccum_signed;

  localparam int BWID_IN  = 33;
  localparam int BWID_ACC = 48;
  localparam int BWID_OUT = 16;
  localparam int SHIFT    = 8;
  localparam int LEN      = 4;

  logic                       clk;
  logic                       rst;
  logic                       iValid;
  logic signed [BWID_IN-1:0]  iData;
  logic                       iClr;
  logic                       oValid;
  logic signed [BWID_OUT-1:0] oData;
  logic                       oSat;
  logic                       oBusy;

  xaccum_signed #(
    .BWID_IN (BWID_IN),
    .BWID_ACC(BWID_ACC),
    .BWID_OUT(BWID_OUT),
    .SHIFT   (SHIFT),
    .LEN     (LEN)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .iValid(iValid),
    .iData (iData),
    .iClr  (iClr),
    .oValid(oValid),
    .oData (oData),
    .oSat  (oSat),
    .oBusy (oBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint data;
    bit     sat;
    int     due;
  } exp_t;

  exp_t   expQ[$];
  exp_t   front;
  int     checks   = 0;
  int     errors   = 0;
  int     cycle    = 0;
  int     mCnt     = 0;
  longint mAcc     = 0;
  longint lastData = 0;
  bit     lastSat  = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input longint got,
                             input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
               tag, got, want, cycle);
    end
  endtask

  // floor((sum + 2^(SHIFT-1)) / 2^SHIFT), then clip to the output range.
  function automatic void modelBlock(input longint sum, output longint res,
                                     output bit sat);
    longint den;
    longint num;
    longint q;
    longint hi;
    longint lo;
    den = longint'(1) << SHIFT;
    num = sum + ((SHIFT > 0) ? (longint'(1) << (SHIFT - 1)) : longint'(0));
    q   = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    hi  = (longint'(1) << (BWID_OUT - 1)) - 1;
    lo  = -(longint'(1) << (BWID_OUT - 1));
    sat = 1'b0;
    res = q;
    if (q > hi) begin
      res = hi;
      sat = 1'b1;
    end else if (q < lo) begin
      res = lo;
      sat = 1'b1;
    end
  endfunction

  // One clock of stimulus: checks oBusy from the previous step, drives the
  // new inputs and advances the model for the sample accepted next edge.
  task automatic applyStimulus(input bit v, input longint d, input bit c);
    longint r;
    bit     s;
    exp_t   n;
    @(posedge clk);
    #1;
    checkOutput("oBusy", oBusy, (mCnt != 0));
    iValid = v;
    iData  = d[BWID_IN-1:0];
    iClr   = c;
    if (c) mCnt = 0;
    if (v) begin
      if (mCnt == 0) mAcc = d;
      else           mAcc = mAcc + d;
      mCnt++;
      if (mCnt == LEN) begin
        mCnt = 0;
        modelBlock(mAcc, r, s);
        n.data = r;
        n.sat  = s;
        n.due  = cycle + 3;
        expQ.push_back(n);
      end
    end
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1;
    rst    = 1'b1;
    iValid = 1'b0;
    iClr   = 1'b0;
    iData  = '0;
    expQ.delete();
    mCnt     = 0;
    mAcc     = 0;
    lastData = 0;
    lastSat  = 1'b0;
    #2;
    checkOutput("reset oValid", oValid, 0);
    checkOutput("reset oData", oData, 0);
    checkOutput("reset oSat", oSat, 0);
    checkOutput("reset oBusy", oBusy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 0, 1'b0);
  endtask

  task automatic block4(input longint a, input longint b, input longint c,
                        input longint d);
    applyStimulus(1'b1, a, 1'b0);
    applyStimulus(1'b1, b, 1'b0);
    applyStimulus(1'b1, c, 1'b0);
    applyStimulus(1'b1, d, 1'b0);
  endtask

  // Every cycle out of reset: either a result is due exactly now, or there
  // must be no strobe and the previous result must still be held.
  always @(negedge clk) begin
    if (!rst) begin
      if (expQ.size() > 0 && expQ[0].due == cycle) begin
        front = expQ.pop_front();
        checkOutput("oValid strobe", oValid, 1);
        checkOutput("oData", oData, front.data);
        checkOutput("oSat", oSat, front.sat);
        lastData = front.data;
        lastSat  = front.sat;
      end else begin
        checkOutput("spurious oValid", oValid, 0);
        checkOutput("oData hold", oData, lastData);
        checkOutput("oSat hold", oSat, lastSat);
      end
    end
  end

  initial begin
    longint d;
    int     gap;
    rst    = 1'b0;
    iValid = 1'b0;
    iClr   = 1'b0;
    iData  = '0;
    #1;
    rst = 1'b1;
    #2;
    checkOutput("initial oValid", oValid, 0);
    checkOutput("initial oData", oData, 0);
    checkOutput("initial oSat", oSat, 0);
    checkOutput("initial oBusy", oBusy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] basic sum");
    block4(256, 512, 768, 1024);
    idle(4);

    $display("[TB] rounding");
    block4(128, 0, 0, 0);
    block4(127, 0, 0, 0);
    block4(-129, 0, 0, 0);
    block4(-128, 0, 0, 0);
    idle(4);

    $display("[TB] saturation");
    block4(4194304, 4194304, 4194304, 4194304);
    block4(-4194304, -4194304, -4194304, -4194304);
    block4(256, 0, 0, 0);
    idle(4);

    $display("[TB] clear");
    applyStimulus(1'b1, 1000, 1'b0);
    applyStimulus(1'b1, 1000, 1'b0);
    applyStimulus(1'b1, 256, 1'b1);
    applyStimulus(1'b1, 256, 1'b0);
    applyStimulus(1'b1, 256, 1'b0);
    applyStimulus(1'b1, 256, 1'b0);
    idle(4);
    applyStimulus(1'b1, 1000, 1'b0);
    applyStimulus(1'b1, 1000, 1'b0);
    applyStimulus(1'b0, 0, 1'b1);
    idle(4);

    $display("[TB] random gaps, back-to-back blocks");
    for (int blk = 0; blk < 6; blk++) begin
      for (int s = 0; s < LEN; s++) begin
        if (s > 0) begin
          gap = int'($urandom_range(0, 2));
          idle(gap);
        end
        d = longint'($urandom_range(0, 4000000)) - 2000000;
        if (blk == 2 || blk == 4) d = d * 4;
        applyStimulus(1'b1, d, 1'b0);
      end
    end
    idle(5);

    $display("[TB] reset");
    applyStimulus(1'b1, 256, 1'b0);
    applyStimulus(1'b1, 256, 1'b0);
    applyReset();
    idle(5);
    block4(256, 256, 256, 256);
    applyReset();
    idle(5);
    block4(256, 256, 256, 256);
    idle(5);

    checkOutput("results outstanding", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
